audio_interval_envelope: RTL and testbench
==========================================

# audio_interval_envelope

Streaming, multi-channel successor to the fixed-size interval min/max block. Consumes a valid/ready stream of signed audio samples (CH channels per beat) and emits per-interval minimum and maximum for every channel. Interval length and interval count are runtime-programmable. Sits between the audio capture FIFO and the envelope/feature extraction stage of the analysis pipeline.

## Interface
- DATA_W, 32, sample width (signed, two's complement)
- CH, 2, channels per input beat
- LEN_W, 16, width of interval_len
- CNT_W, 16, width of num_intervals and out_index
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a run (accepted only in IDLE)
- interval_len  in  LEN_W  samples per interval, latched on start; 0 treated as 1
- num_intervals  in  CNT_W  intervals per run, latched on start; 0 = free-running until reset
- in_valid  in  1  sample beat valid
- in_ready  out  1  block accepts beat
- in_data  in  CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
- out_valid  out  1  result register holds a result
- out_ready  in  1  downstream accepts result
- out_min  out  CH*DATA_W  per-channel interval minimum, same packing
- out_max  out  CH*DATA_W  per-channel interval maximum
- out_index  out  CNT_W  interval number, 0-based, wraps at 2^CNT_W
- out_last  out  1  result is the final interval of the run
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of run

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: in_ready=0. On start: latch len=max(interval_len,1) and num_intervals; clear the sample counter, interval counter and first-sample flag; go to RUN. Start outside IDLE is ignored.
- RUN: a beat is accepted when in_valid && in_ready.
  - First beat of an interval: min and max for each channel are loaded with that sample.
  - Later beats: min and max are updated independently. Both are compared every beat; there is no else-if priority.
  - All comparisons are signed, DATA_W wide, with no truncation.
- Interval completes on the accepted beat where sample_cnt == len-1. On that edge:
  - The result register is loaded with min/max including this beat, plus out_index and out_last.
  - out_valid is set.
  - sample_cnt is cleared and the accumulators are marked for reseed.
- out_last=1 when interval_cnt == num_intervals-1 and num_intervals != 0. After loading the last result, go to DRAIN; in_ready=0.
- Backpressure: the result register is single-entry.
  - in_ready = (state==RUN) && !(sample_cnt==len-1 && out_valid && !out_ready).
  - Non-final beats are always accepted in RUN, even while a result is pending.
- Output handshake: the result is held stable while out_valid && !out_ready. out_valid clears on acceptance unless a new result loads on the same edge.
- DRAIN: when the last result is accepted, go to IDLE and pulse done.
- Free-running mode (num_intervals=0): out_last is never set, DRAIN is never entered, and out_index wraps.
- Reset in any state:
  - State goes to IDLE.
  - All outputs go to 0: in_ready, out_valid, out_min, out_max, out_index, out_last, busy, done.
  - The partial interval is discarded.

## Timing
- Latency: the result is visible (out_valid=1) in the cycle after the handshake of the interval's last beat.
- Throughput: 1 beat/cycle while downstream keeps up. With len=1, one result per cycle requires out_ready held high.
- in_ready is combinational from state, sample_cnt, out_valid and out_ready. There is no combinational path from in_valid to in_ready.
- busy rises the cycle after start and falls in the same cycle done pulses.
- done is high for exactly one cycle, in the cycle after the final out_valid && out_ready.
- Simultaneous result accept and new result load: the new result wins, out_valid stays 1, and there is no bubble.

## Test plan
- Run with CH=2, len=4, num=2. ch0 samples 5,-3,7,0 then 1,1,1,1; ch1 negated. Required results:
  - Index 0: ch0 min=-3/max=7, ch1 min=-7/max=3.
  - Index 1: ch0 1/1, ch1 -1/-1, with out_last=1.
  - done pulses once, in the cycle after the index-1 accept.
- Monotonic increasing samples 1..8, len=8: min=1, max=8. This checks the independent min/max update (no else-if).
- Extremes: samples 0x80000000 and 0x7FFFFFFF, len=2 → min=-2147483648, max=2147483647.
- Backpressure: out_ready=0 for 10 cycles, len=3. Required behaviour:
  - The second interval's 3rd beat is stalled (in_ready=0).
  - The first result is held unchanged.
  - Releasing out_ready yields both results in order with no loss.
- interval_len=0 with num=3, samples 9,-2,4: three results with min=max=sample each.
- Reset asserted mid-interval, after 2 of 4 beats: all outputs are 0 the next cycle. A new start and 4 beats give a result computed only from post-reset samples.

Source files
------------

// File: rtl/audio_interval_envelope.sv
// Streaming per-channel interval min/max over a valid/ready sample stream.
// Runtime-programmable interval length and count, single-entry result register.
module audio_interval_envelope #(
  parameter int DATA_W = 32,
  parameter int CH     = 2,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_W-1:0]     interval_len,
  input  logic [CNT_W-1:0]     num_intervals,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DATA_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*DATA_W-1:0] out_min,
  output logic [CH*DATA_W-1:0] out_max,
  output logic [CNT_W-1:0]     out_index,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_next;

  logic [LEN_W-1:0]     len_q;
  logic [CNT_W-1:0]     num_q;
  logic [LEN_W-1:0]     sample_cnt;
  logic [CNT_W-1:0]     interval_cnt;
  logic                 first;
  logic [CH*DATA_W-1:0] acc_min, acc_max;
  logic [CH*DATA_W-1:0] next_min, next_max;
  logic                 last_beat, accept, complete, last_int, done_next;

  assign last_beat = (sample_cnt == len_q - LEN_W'(1));
  // Only the interval-closing beat needs a free result slot; earlier beats just accumulate.
  assign in_ready  = (state == RUN) && !(last_beat && out_valid && !out_ready);
  assign accept    = in_valid && in_ready;
  assign complete  = accept && last_beat;
  assign last_int  = (num_q != '0) && (interval_cnt == num_q - CNT_W'(1));
  assign busy      = (state != IDLE);

  always_comb begin
    next_min = acc_min;
    next_max = acc_max;
    for (int unsigned c = 0; c < CH; c++) begin
      if (first || ($signed(in_data[c*DATA_W +: DATA_W]) < $signed(acc_min[c*DATA_W +: DATA_W])))
        next_min[c*DATA_W +: DATA_W] = in_data[c*DATA_W +: DATA_W];
      if (first || ($signed(in_data[c*DATA_W +: DATA_W]) > $signed(acc_max[c*DATA_W +: DATA_W])))
        next_max[c*DATA_W +: DATA_W] = in_data[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    unique case (state)
      IDLE:  if (start) state_next = RUN;
      RUN:   if (complete && last_int) state_next = DRAIN;
      DRAIN: if (out_valid && out_ready) begin
               state_next = IDLE;
               done_next  = 1'b1;
             end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q        <= LEN_W'(1);
      num_q        <= '0;
      sample_cnt   <= '0;
      interval_cnt <= '0;
      first        <= 1'b1;
      acc_min      <= '0;
      acc_max      <= '0;
      out_valid    <= 1'b0;
      out_min      <= '0;
      out_max      <= '0;
      out_index    <= '0;
      out_last     <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= done_next;
      if (state == IDLE && start) begin
        len_q        <= (interval_len == '0) ? LEN_W'(1) : interval_len;
        num_q        <= num_intervals;
        sample_cnt   <= '0;
        interval_cnt <= '0;
        first        <= 1'b1;
      end
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (accept) begin
        acc_min <= next_min;
        acc_max <= next_max;
        if (last_beat) begin
          sample_cnt   <= '0;
          first        <= 1'b1;
          out_min      <= next_min;
          out_max      <= next_max;
          out_index    <= interval_cnt;
          out_last     <= last_int;
          out_valid    <= 1'b1;
          interval_cnt <= interval_cnt + CNT_W'(1);
        end else begin
          sample_cnt <= sample_cnt + LEN_W'(1);
          first      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_interval_envelope.sv
// Directed vector bench for audio_interval_envelope (CH=2, DATA_W=32).
module tb_audio_interval_envelope;

  localparam int DW = 32;
  localparam int NC = 2;
  localparam int LW = 16;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [LW-1:0]     interval_len;
  logic [CW-1:0]     num_intervals;
  logic              in_valid;
  logic              in_ready;
  logic [NC*DW-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [NC*DW-1:0]  out_min;
  logic [NC*DW-1:0]  out_max;
  logic [CW-1:0]     out_index;
  logic              out_last;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  audio_interval_envelope #(
    .DATA_W (DW),
    .CH     (NC),
    .LEN_W  (LW),
    .CNT_W  (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .interval_len  (interval_len),
    .num_intervals (num_intervals),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_min       (out_min),
    .out_max       (out_max),
    .out_index     (out_index),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done)
  );

  typedef struct {
    bit          st;
    logic [15:0] len;
    logic [15:0] num;
    logic [31:0] d0, d1;
    bit          chk;
    logic [31:0] mn0, mx0, mn1, mx1;
    logic [15:0] idx;
    bit          last;
  } vec_t;

  vec_t tbl[$];
  int vectors     = 0;
  int miscompares = 0;

  function automatic vec_t mk(bit st, int len, int num, int d0, int d1, bit c,
                              int mn0, int mx0, int mn1, int mx1, int idx, bit last);
    vec_t v;
    v.st = st; v.len = 16'(len); v.num = 16'(num);
    v.d0 = d0; v.d1 = d1; v.chk = c;
    v.mn0 = mn0; v.mx0 = mx0; v.mn1 = mn1; v.mx1 = mx1;
    v.idx = 16'(idx); v.last = last;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] l, input logic [15:0] n);
    start = 1'b1; interval_len = l; num_intervals = n;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic send_beat(input logic [31:0] d0, input logic [31:0] d1);
    int w;
    in_valid = 1'b1;
    in_data  = {d1, d0};
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [31:0] mn0, input logic [31:0] mx0,
                              input logic [31:0] mn1, input logic [31:0] mx1,
                              input logic [15:0] idx, input bit last);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_min0"},  out_min[31:0],  mn0);
    chk({tag, "_max0"},  out_max[31:0],  mx0);
    chk({tag, "_min1"},  out_min[63:32], mn1);
    chk({tag, "_max1"},  out_max[63:32], mx1);
    chk({tag, "_index"}, 32'(out_index), 32'(idx));
    chk({tag, "_last"},  32'(out_last),  32'(last));
  endtask

  initial begin
    // Test-plan run: len=4, num=2, ch1 is ch0 negated
    tbl.push_back(mk(1, 4, 2,  5, -5, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4, 2, -3,  3, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4, 2,  7, -7, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4, 2,  0,  0, 1, -3, 7, -7, 3, 0, 0));
    tbl.push_back(mk(0, 4, 2,  1, -1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4, 2,  1, -1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4, 2,  1, -1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4, 2,  1, -1, 1, 1, 1, -1, -1, 1, 1));
    // Monotonic ramp, len=8
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(k == 1, 8, 1, k, -k, k == 8, 1, 8, -8, -1, 0, 1));
    // Signed extremes, len=2
    tbl.push_back(mk(1, 2, 1, 32'sh80000000, 32'sh7FFFFFFF, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2, 1, 32'sh7FFFFFFF, 32'sh80000000, 1,
                     32'sh80000000, 32'sh7FFFFFFF, 32'sh80000000, 32'sh7FFFFFFF, 0, 1));
    // interval_len=0 behaves as 1
    tbl.push_back(mk(1, 0, 3,  9, -9, 1,  9,  9, -9, -9, 0, 0));
    tbl.push_back(mk(0, 0, 3, -2,  2, 1, -2, -2,  2,  2, 1, 0));
    tbl.push_back(mk(0, 0, 3,  4, -4, 1,  4,  4, -4, -4, 2, 1));

    reset = 1'b1; start = 1'b0; interval_len = '0; num_intervals = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready",  32'(in_ready),  32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy",      32'(busy),      32'd0);
    chk("reset_done",      32'(done),      32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      if (tbl[i].st) do_start(tbl[i].len, tbl[i].num);
      send_beat(tbl[i].d0, tbl[i].d1);
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].chk));
      if (tbl[i].chk)
        check_result($sformatf("v%0d", i), tbl[i].mn0, tbl[i].mx0, tbl[i].mn1, tbl[i].mx1,
                     tbl[i].idx, tbl[i].last);
      if (tbl[i].chk && tbl[i].last) begin
        @(posedge clk); #1;
        chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
        chk($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
        chk($sformatf("v%0d_valid_end", i), 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_done_once", i), 32'(done), 32'd0);
      end
    end

    // Backpressure: len=3, num=2, downstream stalled
    out_ready = 1'b0;
    do_start(16'd3, 16'd2);
    send_beat(32'd1, -32'sd1);
    send_beat(32'd2, -32'sd2);
    send_beat(32'd3, -32'sd3);
    check_result("bp_r0", 32'd1, 32'd3, -32'sd3, -32'sd1, 16'd0, 1'b0);
    send_beat(32'd4, -32'sd4);
    send_beat(32'd5, -32'sd5);
    in_valid = 1'b1;
    in_data  = {-32'sd6, 32'd6};
    for (int k = 0; k < 5; k++) begin
      #0;
      chk("bp_stall_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    check_result("bp_r0_held", 32'd1, 32'd3, -32'sd3, -32'sd1, 16'd0, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_result("bp_r1", 32'd4, 32'd6, -32'sd6, -32'sd4, 16'd1, 1'b1);
    @(posedge clk); #1;
    chk("bp_done", 32'(done), 32'd1);
    @(posedge clk); #1;

    // Reset mid-interval, then a clean run from post-reset samples
    do_start(16'd4, 16'd1);
    send_beat(32'd100, -32'sd100);
    send_beat(-32'sd50, 32'd50);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_min0",      out_min[31:0],  32'd0);
    chk("rst_max1",      out_max[63:32], 32'd0);
    chk("rst_index",     32'(out_index), 32'd0);
    chk("rst_last",      32'(out_last),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    do_start(16'd4, 16'd1);
    send_beat(32'd3, -32'sd3);
    send_beat(32'd6, -32'sd6);
    send_beat(32'd4, -32'sd4);
    send_beat(32'd5, -32'sd5);
    check_result("post_rst", 32'd3, 32'd6, -32'sd6, -32'sd3, 16'd0, 1'b1);
    @(posedge clk); #1;
    chk("post_rst_done", 32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
